// File: rtl/clock_divider_prog_if.sv
// Configuration request bundle for clock_divider_prog.
// Master drives the request; slave returns cfg_ready.
interface clock_divider_prog_if #(
  parameter int CNT_W  = 5,
  parameter int NUM_CH = 2
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [NUM_CH-1:0] cfg_mask;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_high;

  modport master (
    output cfg_valid,
    output cfg_mask,
    output cfg_period,
    output cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mask,
    input  cfg_period,
    input  cfg_high,
    output cfg_ready
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock-enable divider with shadowed config.
// Optional macro CLOCK_DIVIDER_PROG_ALIGN_EN adds an align input.
module clock_divider_prog #(
  parameter int CNT_W        = 5,
  parameter int NUM_CH       = 2,
  parameter int RESET_PERIOD = 15,
  parameter int RESET_HIGH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
`ifdef CLOCK_DIVIDER_PROG_ALIGN_EN
  input  logic              align,
`endif
  clock_divider_prog_if.slave cfg,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] rise_stb,
  output logic [NUM_CH-1:0] cfg_pending
);

  localparam logic [CNT_W-1:0] RST_PER = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0] RST_HI  = CNT_W'(RESET_HIGH);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] per_q, per_d;
  logic [NUM_CH-1:0][CNT_W-1:0] high_q, high_d;
  logic [NUM_CH-1:0][CNT_W-1:0] per_sh_q, per_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0] high_sh_q, high_sh_d;
  logic [NUM_CH-1:0]            pend_q, pend_d;
  logic [NUM_CH-1:0]            div_q, div_d;
  logic [NUM_CH-1:0]            rise_q, rise_d;

  logic ready;
  logic accept;
  logic align_w;

`ifdef CLOCK_DIVIDER_PROG_ALIGN_EN
  assign align_w = align;
`else
  assign align_w = 1'b0;
`endif

  // High time clipped to the period so H > P+1 reads as constant high.
  function automatic logic [CNT_W:0] eff_high(
    input logic [CNT_W-1:0] per,
    input logic [CNT_W-1:0] high
  );
    logic [CNT_W:0] p1;
    p1 = {1'b0, per} + {{CNT_W{1'b0}}, 1'b1};
    return ({1'b0, high} > p1) ? p1 : {1'b0, high};
  endfunction

  assign ready       = ~|pend_q;
  assign accept      = cfg.cfg_valid & ready;
  assign cfg.cfg_ready = ready;
  assign div_out     = div_q;
  assign rise_stb    = rise_q;
  assign cfg_pending = pend_q;

  // Per-channel counter advance, boundary reload and shadow capture.
  always_comb begin
    cnt_d     = cnt_q;
    per_d     = per_q;
    high_d    = high_q;
    per_sh_d  = per_sh_q;
    high_sh_d = high_sh_q;
    pend_d    = pend_q;
    div_d     = div_q;
    rise_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en) begin
        if (align_w || (cnt_q[i] == per_q[i])) begin
          cnt_d[i] = '0;
          if (pend_q[i]) begin
            per_d[i]  = per_sh_q[i];
            high_d[i] = high_sh_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
        div_d[i]  = ({1'b0, cnt_d[i]} < eff_high(per_d[i], high_d[i]));
        rise_d[i] = div_d[i] & ~div_q[i];
      end
      if (accept && cfg.cfg_mask[i]) begin
        per_sh_d[i]  = cfg.cfg_period;
        high_sh_d[i] = cfg.cfg_high;
        pend_d[i]    = 1'b1;
      end
    end
  end

  // State registers; reset parks counters at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= {NUM_CH{RST_PER}};
      per_q     <= {NUM_CH{RST_PER}};
      high_q    <= {NUM_CH{RST_HI}};
      per_sh_q  <= '0;
      high_sh_q <= '0;
      pend_q    <= '0;
      div_q     <= '0;
      rise_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      high_q    <= high_d;
      per_sh_q  <= per_sh_d;
      high_sh_q <= high_sh_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
      rise_q    <= rise_d;
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed table-driven bench for clock_divider_prog.
// Covers defaults, reload, extremes, gating, async reset, align.
module tb_clock_divider_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       align;
  logic [1:0] div_out;
  logic [1:0] rise_stb;
  logic [1:0] cfg_pending;

  clock_divider_prog_if #(.CNT_W(5), .NUM_CH(2)) cif ();

  clock_divider_prog #(
    .CNT_W(5), .NUM_CH(2), .RESET_PERIOD(15), .RESET_HIGH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
`ifdef CLOCK_DIVIDER_PROG_ALIGN_EN
    .align(align),
`endif
    .cfg(cif),
    .div_out(div_out),
    .rise_stb(rise_stb),
    .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       vld;
    logic [1:0] mask;
    logic [4:0] per;
    logic [4:0] hi;
    logic [1:0] div;
    logic [1:0] rise;
    logic [1:0] pend;
  } vec_t;

  localparam int NV = 88;
  vec_t tbl [NV];

  int total;
  int bad;
  int c0, c1;
  logic d0, r0, d1, r1, p0, p1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] d,
                         input logic [1:0] r, input logic [1:0] p);
    check({tag, " div"}, {6'b0, div_out}, {6'b0, d});
    check({tag, " rise"}, {6'b0, rise_stb}, {6'b0, r});
    check({tag, " pend"}, {6'b0, cfg_pending}, {6'b0, p});
    check({tag, " ready"}, {7'b0, cif.cfg_ready}, {7'b0, ~|p});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Edge k (1-based) after reset release, en held high throughout.
    // ch0 reloads to P=4,H=2 at edge 33; ch1 to P=5,H=0 at 65,
    // P=5,H=31 at 71, P=0,H=1 at 83.
    for (int k = 1; k <= NV; k++) begin
      if (k < 33) begin
        c0 = (k - 1) % 16; d0 = (c0 < 8); r0 = (c0 == 0);
      end else begin
        c0 = (k - 33) % 5; d0 = (c0 < 2); r0 = (c0 == 0);
      end
      if (k < 65) begin
        c1 = (k - 1) % 16; d1 = (c1 < 8); r1 = (c1 == 0);
      end else if (k < 71) begin
        d1 = 1'b0; r1 = 1'b0;
      end else begin
        d1 = 1'b1; r1 = (k == 71);
      end
      p0 = (k >= 18 && k <= 32);
      p1 = (k >= 49 && k <= 64) || (k >= 66 && k <= 70) ||
           (k >= 81 && k <= 82);
      tbl[k-1].en   = 1'b1;
      tbl[k-1].vld  = 1'b0;
      tbl[k-1].mask = 2'b00;
      tbl[k-1].per  = 5'd0;
      tbl[k-1].hi   = 5'd0;
      tbl[k-1].div  = {d1, d0};
      tbl[k-1].rise = {r1, r0};
      tbl[k-1].pend = {p1, p0};
    end
    tbl[17].vld = 1; tbl[17].mask = 2'b01; tbl[17].per = 4; tbl[17].hi = 2;
    tbl[19].vld = 1; tbl[19].mask = 2'b11; tbl[19].per = 1; tbl[19].hi = 1;
    tbl[48].vld = 1; tbl[48].mask = 2'b10; tbl[48].per = 5; tbl[48].hi = 0;
    tbl[65].vld = 1; tbl[65].mask = 2'b10; tbl[65].per = 5; tbl[65].hi = 31;
    tbl[80].vld = 1; tbl[80].mask = 2'b10; tbl[80].per = 0; tbl[80].hi = 1;
    tbl[84].vld = 1; tbl[84].mask = 2'b00; tbl[84].per = 3; tbl[84].hi = 3;

    rst_n = 1'b0;
    en    = 1'b0;
    align = 1'b0;
    cif.cfg_valid  = 1'b0;
    cif.cfg_mask   = '0;
    cif.cfg_period = '0;
    cif.cfg_high   = '0;
    step();
    step();
    chk_all("reset", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      en             = tbl[i].en;
      cif.cfg_valid  = tbl[i].vld;
      cif.cfg_mask   = tbl[i].mask;
      cif.cfg_period = tbl[i].per;
      cif.cfg_high   = tbl[i].hi;
      step();
      chk_all($sformatf("vec%0d", i + 1), tbl[i].div, tbl[i].rise,
              tbl[i].pend);
    end

    // Gating mid-high on ch0 (cnt0=0), with a config accepted while off.
    en = 1'b0;
    cif.cfg_valid  = 1'b1;
    cif.cfg_mask   = 2'b01;
    cif.cfg_period = 5'd9;
    cif.cfg_high   = 5'd9;
    step();
    cif.cfg_valid = 1'b0;
    chk_all("gate0", 2'b11, 2'b00, 2'b01);
    for (int i = 1; i < 10; i++) begin
      step();
      chk_all($sformatf("gate%0d", i), 2'b11, 2'b00, 2'b01);
    end
    en = 1'b1;
    step();
    chk_all("resume1", 2'b11, 2'b00, 2'b01);
    step();
    chk_all("resume2", 2'b10, 2'b00, 2'b01);

    // Asynchronous reset between edges while ch0 is pending.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2'b00, 2'b00, 2'b00);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      c0 = (k - 1) % 16;
      d0 = (c0 < 8);
      r0 = (c0 == 0);
      step();
      chk_all($sformatf("post_rst%0d", k), {d0, d0}, {r0, r0}, 2'b00);
    end

`ifdef CLOCK_DIVIDER_PROG_ALIGN_EN
    cif.cfg_valid  = 1'b1;
    cif.cfg_mask   = 2'b01;
    cif.cfg_period = 5'd3;
    cif.cfg_high   = 5'd2;
    step();
    cif.cfg_valid = 1'b0;
    check("al_pend0", {6'b0, cfg_pending}, 8'h01);
    align = 1'b1;
    step();
    align = 1'b0;
    check("al_div0", {6'b0, div_out}, 8'h03);
    check("al_pend1", {6'b0, cfg_pending}, 8'h00);
    cif.cfg_valid  = 1'b1;
    cif.cfg_mask   = 2'b10;
    cif.cfg_period = 5'd7;
    cif.cfg_high   = 5'd4;
    step();
    cif.cfg_valid = 1'b0;
    step();
    step();
    align = 1'b1;
    step();
    align = 1'b0;
    check("al_div1", {6'b0, div_out}, 8'h03);
    check("al_pend2", {6'b0, cfg_pending}, 8'h00);
    repeat (3) step();
    step();
    check("al_rise4", {6'b0, rise_stb}, 8'h01);
    repeat (3) step();
    step();
    check("al_rise8", {6'b0, rise_stb}, 8'h03);
    repeat (7) step();
    step();
    check("al_rise16", {6'b0, rise_stb}, 8'h03);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
